// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller driving the combinational ALU: registers one request,
// captures the ALU result and flags, and returns them on a valid/ready response port.
// Optional build macro ALU_ISSUE_PIPE_EN overlaps the next accept with the response handshake.
//
// state | meaning
// IDLE  | waiting for a request, reqReady high
// EXEC  | operands/controls held stable on the ALU inputs, result captured on next edge
// RESP  | response presented until rspReady; illegal ops arrive here directly
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [3:0]  reqOp,
    input  logic        reqShiftDir,
    input  logic        reqShiftOp,
    input  logic        reqSetFlags,
    input  logic [31:0] reqA,
    input  logic [31:0] reqB,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ALUctrlOP,
    output logic        shiftDir,
    output logic        shiftOp,
    input  logic [31:0] ALUres,
    input  logic        zeroFlag,
    input  logic        signFlag,
    input  logic        carryFlag,
    input  logic        overflow,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspResult,
    output logic        rspErr,
    output logic        flagZ,
    output logic        flagS,
    output logic        flagC,
    output logic        flagV,
    output logic [15:0] opCount
);

    localparam logic [3:0] OP_XOR   = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_COMPL = 4'b0011;
    localparam logic [3:0] OP_SHIFT = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   op_legal;
    logic   accept;
    logic   rsp_fire;
    logic   set_flags_q;

    always_comb begin
        case (reqOp)
            OP_XOR, OP_AND, OP_ADD, OP_COMPL, OP_SHIFT: op_legal = 1'b1;
            default:                                    op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        reqReady  = 1'b0;
        rspValid  = 1'b0;
        case (state)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) state_nxt = op_legal ? EXEC : RESP;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rspValid = 1'b1;
`ifdef ALU_ISSUE_PIPE_EN
                reqReady = rspReady;
`endif
                if (rspReady) begin
                    state_nxt = IDLE;
`ifdef ALU_ISSUE_PIPE_EN
                    if (reqValid) state_nxt = op_legal ? EXEC : RESP;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = reqValid && reqReady;
    assign rsp_fire = rspValid && rspReady;

    // Illegal ops never touch the ALU-facing registers, so the ALU keeps its last inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A           <= '0;
            B           <= '0;
            ALUctrlOP   <= '0;
            shiftDir    <= 1'b0;
            shiftOp     <= 1'b0;
            set_flags_q <= 1'b0;
        end else if (accept && op_legal) begin
            A           <= reqA;
            ALUctrlOP   <= reqOp;
            set_flags_q <= reqSetFlags;
            shiftDir    <= 1'b0;
            shiftOp     <= 1'b0;
            case (reqOp)
                OP_SHIFT: begin
                    B        <= {27'b0, reqB[4:0]};
                    shiftDir <= reqShiftDir;
                    shiftOp  <= reqShiftOp;
                end
                OP_COMPL: B <= '0;
                default:  B <= reqB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rspResult <= '0;
            rspErr    <= 1'b0;
            flagZ     <= 1'b0;
            flagS     <= 1'b0;
            flagC     <= 1'b0;
            flagV     <= 1'b0;
        end else if (state == EXEC) begin
            rspResult <= ALUres;
            rspErr    <= 1'b0;
            if (set_flags_q) begin
                flagZ <= zeroFlag;
                flagS <= signFlag;
                flagC <= carryFlag;
                flagV <= overflow;
            end
        end else if (accept && !op_legal) begin
            rspResult <= '0;
            rspErr    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        opCount <= '0;
        else if (rsp_fire) opCount <= opCount + 16'd1;
    end

endmodule
